// File: rtl/led_ctrl_pkg.sv
// Shared types and defaults for the LED step scheduler and its debouncer.
package led_ctrl_pkg;

    // Debounce FSM states.
    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_e;

    // Encoding of step_src.
    localparam logic STEP_SRC_MANUAL = 1'b0;
    localparam logic STEP_SRC_AUTO   = 1'b1;

    // Default configuration values.
    localparam int unsigned DEF_DEBOUNCE_CYCLES  = 4;
    localparam int unsigned DEF_DWELL_W          = 16;
    localparam int unsigned DEF_LONGPRESS_CYCLES = 64;

endpackage

// File: rtl/led_debounce.sv
// Two-flop synchroniser plus press/release debounce FSM for the board pushbutton.
// press_req is a combinational one-cycle pulse on the PRESS_WAIT -> PRESSED transition.
module led_debounce
    import led_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button_in,
    output logic btn_state,
    output logic press_req,
    output logic pressed
);

    localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("led_debounce: DEBOUNCE_CYCLES must be at least 2");
    end

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // Synchroniser inputs.
    always_comb begin
        sync1_d = button_in;
        sync2_d = sync1_q;
    end

    // State, counter and synchroniser registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= RELEASED;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; a press is accepted only after DEBOUNCE_CYCLES stable samples.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_req = 1'b0;
        case (state_q)
            RELEASED: begin
                if (sync2_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!sync2_q) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = PRESSED;
                    cnt_d     = '0;
                    press_req = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!sync2_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (sync2_q) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    // Level outputs decoded from the state register.
    always_comb begin
        btn_state = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
        pressed   = (state_q == PRESSED);
    end

endmodule

// File: rtl/led_step_scheduler.sv
// Step pulse generator for the LED colour cycler: debounced manual button plus
// a programmable auto-advance dwell timer, manual requests taking priority.
// Optional feature macro: LED_STEP_LONGPRESS_EN (long press toggles auto pause).
module led_step_scheduler
    import led_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned DWELL_W          = DEF_DWELL_W,
    parameter int unsigned LONGPRESS_CYCLES = DEF_LONGPRESS_CYCLES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               button_in,
    input  logic               auto_en,
    input  logic [DWELL_W-1:0] dwell,
    output logic               step,
    output logic               step_src,
    output logic               btn_state,
    output logic               auto_active
);

    if (LONGPRESS_CYCLES < 1) begin : g_bad_longpress
        $error("led_step_scheduler: LONGPRESS_CYCLES must be at least 1");
    end

    logic               press_req;
    logic               pressed;
    logic               db_btn_state;
    logic               pause;
    logic               auto_req_c;
    logic               unused_pressed;

    logic               step_q,        step_d;
    logic               step_src_q,    step_src_d;
    logic               auto_active_q, auto_active_d;
    logic [DWELL_W-1:0] cnt_q,         cnt_d;

    led_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .button_in (button_in),
        .btn_state (db_btn_state),
        .press_req (press_req),
        .pressed   (pressed)
    );

    // The long-press counter keys off btn_state so it keeps running through RELEASE_WAIT.
    assign unused_pressed = pressed;

`ifdef LED_STEP_LONGPRESS_EN
    localparam int unsigned          LP_W   = $clog2(LONGPRESS_CYCLES + 1);
    localparam logic [LP_W-1:0]      LP_MAX = LP_W'(LONGPRESS_CYCLES);
    localparam logic [LP_W-1:0]      LP_ONE = LP_W'(1);

    logic [LP_W-1:0] lp_cnt_q, lp_cnt_d;
    logic            pause_q,  pause_d;

    // Long-press counter saturates so pause toggles exactly once per press.
    always_comb begin
        lp_cnt_d = lp_cnt_q;
        pause_d  = pause_q;
        if (!db_btn_state) begin
            lp_cnt_d = '0;
        end else if (lp_cnt_q != LP_MAX) begin
            lp_cnt_d = lp_cnt_q + LP_ONE;
            if (lp_cnt_d == LP_MAX) begin
                pause_d = ~pause_q;
            end
        end
    end

    // Long-press registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lp_cnt_q <= '0;
            pause_q  <= 1'b0;
        end else begin
            lp_cnt_q <= lp_cnt_d;
            pause_q  <= pause_d;
        end
    end

    assign pause = pause_q;
`else
    assign pause = 1'b0;
`endif

    // Auto request fires once cnt reaches dwell-1; >= lets a lowered dwell fire at once.
    always_comb begin
        auto_req_c = auto_active_q && (dwell != '0) &&
                     (cnt_q >= (dwell - DWELL_W'(1)));
    end

    // Dwell counter, enable, step and source next-state logic.
    always_comb begin
        auto_active_d = auto_en && (dwell != '0) && !pause;
        step_d        = press_req || auto_req_c;
        step_src_d    = (!press_req && auto_req_c) ? STEP_SRC_AUTO : STEP_SRC_MANUAL;
        cnt_d         = cnt_q;
        if (!auto_active_q || press_req || auto_req_c) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DWELL_W'(1);
        end
    end

    // Output and timer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q        <= 1'b0;
            step_src_q    <= STEP_SRC_MANUAL;
            auto_active_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            step_q        <= step_d;
            step_src_q    <= step_src_d;
            auto_active_q <= auto_active_d;
            cnt_q         <= cnt_d;
        end
    end

    assign step        = step_q;
    assign step_src    = step_src_q;
    assign btn_state   = db_btn_state;
    assign auto_active = auto_active_q;

endmodule

// File: tb/tb_led_step_scheduler.sv
// Directed self-checking bench for led_step_scheduler (DEBOUNCE_CYCLES=4, DWELL_W=16).
module tb_led_step_scheduler;

`ifdef LED_STEP_LONGPRESS_EN
    localparam bit LP_EN = 1'b1;
`else
    localparam bit LP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        button_in;
    logic        auto_en;
    logic [15:0] dwell;
    logic        step;
    logic        step_src;
    logic        btn_state;
    logic        auto_active;

    int n_tests  = 0;
    int n_fail   = 0;
    int src_leak = 0;

    always #5 clk = ~clk;

    led_step_scheduler #(
        .DEBOUNCE_CYCLES  (4),
        .DWELL_W          (16),
        .LONGPRESS_CYCLES (64)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .button_in   (button_in),
        .auto_en     (auto_en),
        .dwell       (dwell),
        .step        (step),
        .step_src    (step_src),
        .btn_state   (btn_state),
        .auto_active (auto_active)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (!step && step_src) src_leak++;
    endtask

    // Advance n cycles, counting steps, the first step index and auto-sourced steps.
    task automatic watch(input int n, output int n_steps, output int first_at, output int n_auto);
        n_steps  = 0;
        first_at = 0;
        n_auto   = 0;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (step) begin
                n_steps++;
                if (first_at == 0) first_at = i;
                if (step_src) n_auto++;
            end
        end
    endtask

    initial begin
        int s, f, a;
        int acc;
        int low_cnt;
        int found;
        int src_seen;

        rst_n     = 1'b0;
        button_in = 1'b0;
        auto_en   = 1'b0;
        dwell     = '0;
        #12;
        chk("rst_step",        32'(step),        0);
        chk("rst_step_src",    32'(step_src),    0);
        chk("rst_btn_state",   32'(btn_state),   0);
        chk("rst_auto_active", 32'(auto_active), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        // Clean press: one manual step six edges after the rise.
        button_in = 1'b1;
        watch(20, s, f, a);
        chk("clean_steps",   32'(s), 1);
        chk("clean_latency", 32'(f), 6);
        chk("clean_src",     32'(a), 0);
        chk("clean_btn",     32'(btn_state), 1);
        button_in = 1'b0;
        watch(12, s, f, a);
        chk("release_steps", 32'(s), 0);
        chk("release_btn",   32'(btn_state), 0);

        // Press bounce 1,0,1,0 then a stable 1.
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            button_in = (i % 2 == 0);
            watch(1, s, f, a);
            acc += s;
        end
        button_in = 1'b1;
        watch(20, s, f, a);
        chk("bounce_quiet",   32'(acc), 0);
        chk("bounce_steps",   32'(s),   1);
        chk("bounce_latency", 32'(f),   6);

        // Release bounce 0,1,0 then held: still pressed, no step.
        low_cnt = 0;
        acc     = 0;
        for (int i = 0; i < 13; i++) begin
            button_in = !((i == 0) || (i == 2));
            tick();
            if (!btn_state) low_cnt++;
            if (step) acc++;
        end
        chk("rbounce_btn_low", 32'(low_cnt), 0);
        chk("rbounce_steps",   32'(acc),     0);
        button_in = 1'b0;
        watch(12, s, f, a);
        chk("rbounce_release_steps", 32'(s), 0);
        chk("rbounce_release_btn",   32'(btn_state), 0);

        // Auto advance every 5 cycles.
        dwell   = 16'd5;
        auto_en = 1'b1;
        tick();
        tick();
        chk("auto_active_on", 32'(auto_active), 1);
        watch(30, s, f, a);
        chk("auto_first", 32'(f), 4);
        chk("auto_count", 32'(s), 6);
        chk("auto_src",   32'(a), 6);

        // dwell=0 disables auto.
        dwell = '0;
        tick();
        tick();
        chk("dwell0_inactive", 32'(auto_active), 0);
        watch(20, s, f, a);
        chk("dwell0_steps", 32'(s), 0);

        // Lower dwell 100 -> 3 at cnt=50.
        dwell = 16'd100;
        watch(51, s, f, a);
        chk("dwell100_quiet", 32'(s), 0);
        dwell = 16'd3;
        watch(1, s, f, a);
        chk("lower_step", 32'(s), 1);
        chk("lower_src",  32'(a), 1);
        watch(3, s, f, a);
        chk("lower_next_steps", 32'(s), 1);
        chk("lower_next_at",    32'(f), 3);

        // Collision: manual acceptance lands on a dwell expiry.
        dwell    = 16'd10;
        found    = 0;
        src_seen = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            tick();
            if (step) begin
                found    = 1;
                src_seen = 32'(step_src);
            end
        end
        chk("coll_sync_found", 32'(found),    1);
        chk("coll_sync_src",   32'(src_seen), 1);
        watch(4, s, f, a);
        chk("coll_pre_steps", 32'(s), 0);
        button_in = 1'b1;
        watch(6, s, f, a);
        chk("coll_steps", 32'(s), 1);
        chk("coll_at",    32'(f), 6);
        chk("coll_src",   32'(a), 0);
        watch(10, s, f, a);
        chk("coll_next_steps", 32'(s), 1);
        chk("coll_next_at",    32'(f), 10);
        chk("coll_next_src",   32'(a), 1);
        button_in = 1'b0;
        auto_en   = 1'b0;
        dwell     = '0;
        watch(12, s, f, a);

        // Async reset in the middle of PRESS_WAIT with the button held.
        auto_en = 1'b1;
        dwell   = 16'd7;
        tick();
        tick();
        chk("prereset_auto_active", 32'(auto_active), 1);
        button_in = 1'b1;
        tick();
        tick();
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_step",        32'(step),        0);
        chk("midrst_step_src",    32'(step_src),    0);
        chk("midrst_btn_state",   32'(btn_state),   0);
        chk("midrst_auto_active", 32'(auto_active), 0);
        auto_en = 1'b0;
        dwell   = '0;
        tick();
        rst_n = 1'b1;
        watch(15, s, f, a);
        chk("postrst_steps",   32'(s), 1);
        chk("postrst_latency", 32'(f), 6);
        chk("postrst_src",     32'(a), 0);
        button_in = 1'b0;
        watch(12, s, f, a);

        // Long press with auto running at dwell=10.
        dwell   = 16'd10;
        auto_en = 1'b1;
        tick();
        tick();
        chk("lp_auto_before", 32'(auto_active), 1);
        button_in = 1'b1;
        watch(100, s, f, a);
        chk("lp1_manual",      32'(s - a), 1);
        chk("lp1_auto_active", 32'(auto_active), 32'(!LP_EN));
        button_in = 1'b0;
        watch(30, s, f, a);
        chk("lp1_after_autosteps", 32'(s != 0), 32'(!LP_EN));
        button_in = 1'b1;
        watch(100, s, f, a);
        chk("lp2_manual",      32'(s - a), 1);
        chk("lp2_auto_active", 32'(auto_active), 1);
        button_in = 1'b0;
        watch(12, s, f, a);

        chk("src_idle_zero", 32'(src_leak), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
